// File: rtl/pico_mc_alu.sv
// picoMIPS execute stage: single-cycle add/sub/li plus an N-cycle shift-add multiply.
// Define PICO_SIGNED_MUL_EN for saturating signed Q1.(N-1) fractional multiply.
module pico_mc_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] imm,
  output logic [N-1:0] result,
  output logic         we,
  output logic         busy,
  output logic         zero
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam int CW = $clog2(N + 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [N-1:0]    mcand;
  logic [N-1:0]    mplier;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  acc_nxt;
  logic [N:0]      psum;
  logic [N-1:0]    alu_res;
  logic [N-1:0]    mul_res;
  logic [N-1:0]    mul_a;
  logic [N-1:0]    mul_b;
  logic            alu_wr;
  logic            is_mul;

  assign busy = (state == MUL);

  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b0;
    is_mul  = 1'b0;
    unique case (op)
      3'b000: begin alu_res = a + b;   alu_wr = 1'b1; end
      3'b001: begin alu_res = a + imm; alu_wr = 1'b1; end
      3'b010: begin alu_res = a - b;   alu_wr = 1'b1; end
      3'b011: begin alu_res = a - imm; alu_wr = 1'b1; end
      3'b100: is_mul = 1'b1;
      3'b101: is_mul = 1'b1;
      3'b110: begin alu_res = imm;     alu_wr = 1'b1; end
      default: ;
    endcase
  end

  // Accumulate into the upper half, then shift the whole product right.
  always_comb begin
    psum    = {1'b0, acc[2*N-1:N]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nxt = {psum, acc[N-1:1]};
  end

  assign mul_b = op[0] ? b : imm;

`ifdef PICO_SIGNED_MUL_EN
  logic           neg;
  logic [2*N-1:0] sprod;
  logic           sat;

  assign mul_a = a[N-1] ? -a : a;

  always_comb begin
    sprod   = neg ? -acc_nxt : acc_nxt;
    sat     = !neg && acc_nxt[2*N-2];
    mul_res = sat ? {1'b0, {(N-1){1'b1}}} : sprod[2*N-2:N-1];
  end

  always_ff @(posedge clk) begin
    if (!reset)
      neg <= 1'b0;
    else if (state == IDLE && start && is_mul)
      neg <= a[N-1] ^ mul_b[N-1];
  end
`else
  assign mul_a   = a;
  assign mul_res = acc_nxt[2*N-1:N];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
      we     <= 1'b0;
      zero   <= 1'b0;
    end else begin
      we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && is_mul) begin
            mcand  <= mul_a;
`ifdef PICO_SIGNED_MUL_EN
            mplier <= mul_b[N-1] ? -mul_b : mul_b;
`else
            mplier <= mul_b;
`endif
            acc    <= '0;
            count  <= CW'(N);
            state  <= MUL;
          end else if (start && alu_wr) begin
            result <= alu_res;
            zero   <= (alu_res == '0);
            we     <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            result <= mul_res;
            zero   <= (mul_res == '0);
            we     <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_mc_alu.sv
// Directed self-checking bench for pico_mc_alu (N=8).
// Signed-multiply vectors run when PICO_SIGNED_MUL_EN is defined.
module tb_pico_mc_alu;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] imm;
  logic [7:0] result;
  logic       we;
  logic       busy;
  logic       zero;

  int checks = 0;
  int fails  = 0;

  pico_mc_alu #(.N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .imm(imm),
    .result(result), .we(we), .busy(busy), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [7:0] va,
                       input logic [7:0] vb, input logic [7:0] vi);
    start = 1'b1; op = o; a = va; b = vb; imm = vi;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    issue(3'b000, 8'h01, 8'h01, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({result, we, busy, zero} !== {8'h00, 3'b000}) begin
        fails++;
        $display("FAIL reset cyc%0d: result=%h we=%b busy=%b zero=%b, want 00 0 0 0",
                 i, result, we, busy, zero);
      end
    end
    reset = 1'b1;
    start = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    issue(3'b000, 8'h05, 8'h03, 8'h00);
    tick();
    checks++;
    if ({result, we, zero} !== {8'h08, 2'b10}) begin
      fails++;
      $display("FAIL add: result=%h we=%b zero=%b, want 08 1 0", result, we, zero);
    end
    issue(3'b010, 8'h03, 8'h03, 8'h00);
    tick();
    checks++;
    if ({result, we, zero} !== {8'h00, 2'b11}) begin
      fails++;
      $display("FAIL sub: result=%h we=%b zero=%b, want 00 1 1", result, we, zero);
    end
    issue(3'b001, 8'hFF, 8'h00, 8'h02);
    tick();
    checks++;
    if ({result, we, zero} !== {8'h01, 2'b10}) begin
      fails++;
      $display("FAIL addi_wrap: result=%h we=%b zero=%b, want 01 1 0", result, we, zero);
    end
    issue(3'b011, 8'h10, 8'h00, 8'h11);
    tick();
    checks++;
    if ({result, we, zero} !== {8'hFF, 2'b10}) begin
      fails++;
      $display("FAIL subi_wrap: result=%h we=%b zero=%b, want ff 1 0", result, we, zero);
    end
    start = 1'b0;
    tick();
    checks++;
    if ({result, we, zero} !== {8'hFF, 2'b00}) begin
      fails++;
      $display("FAIL idle_hold: result=%h we=%b zero=%b, want ff 0 0", result, we, zero);
    end
  endtask

  task automatic test_mul_run(input string name, input logic [2:0] o,
                              input logic [7:0] va, input logic [7:0] vb,
                              input logic [7:0] vi, input logic [7:0] want);
    int busy_cyc;
    busy_cyc = 0;
    issue(o, va, vb, vi);
    tick();
    start = 1'b0;
    a = 8'h00; b = 8'h00; imm = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1 && we === 1'b0) busy_cyc++;
      tick();
    end
    checks++;
    if (busy_cyc != 8) begin
      fails++;
      $display("FAIL %s busy_len: busy cycles=%0d, want 8", name, busy_cyc);
    end
    checks++;
    if ({result, we, busy} !== {want, 2'b10}) begin
      fails++;
      $display("FAIL %s done: result=%h we=%b busy=%b, want %h 1 0",
               name, result, we, busy, want);
    end
    tick();
    checks++;
    if (we !== 1'b0) begin
      fails++;
      $display("FAIL %s we_pulse: we=%b, want 0", name, we);
    end
  endtask

  task automatic test_start_during_busy;
    int pulses;
    logic [7:0] got;
    logic [7:0] want;
`ifdef PICO_SIGNED_MUL_EN
    want = 8'h02;
`else
    want = 8'h01;
`endif
    pulses = 0;
    got = 8'hXX;
    issue(3'b101, 8'h10, 8'h10, 8'h00);
    tick();
    start = 1'b0;
    for (int i = 1; i < 14; i++) begin
      if (i == 2) issue(3'b110, 8'h00, 8'h00, 8'hAA);
      if (i == 3) start = 1'b0;
      tick();
      if (we === 1'b1) begin
        pulses++;
        got = result;
      end
    end
    checks++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL busy_start pulses: we pulses=%0d, want 1", pulses);
    end
    checks++;
    if (got !== want || result !== want) begin
      fails++;
      $display("FAIL busy_start result: result=%h, want %h", result, want);
    end
  endtask

  task automatic test_reset_mid_mul;
    int pulses;
    pulses = 0;
    issue(3'b100, 8'hFF, 8'h00, 8'hFF);
    tick();
    start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      if (we === 1'b1) pulses++;
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({result, we, busy} !== {8'h00, 2'b00}) begin
      fails++;
      $display("FAIL rst_mul abort: result=%h we=%b busy=%b, want 00 0 0",
               result, we, busy);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (we === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mul no_we: pulses=%0d busy=%b, want 0 0", pulses, busy);
    end
    issue(3'b110, 8'h00, 8'h00, 8'h33);
    tick();
    start = 1'b0;
    checks++;
    if ({result, we} !== {8'h33, 1'b1}) begin
      fails++;
      $display("FAIL rst_mul li: result=%h we=%b, want 33 1", result, we);
    end
  endtask

  task automatic test_reserved;
    issue(3'b110, 8'h00, 8'h00, 8'h5A);
    tick();
    issue(3'b111, 8'h01, 8'h02, 8'h00);
    tick();
    start = 1'b0;
    checks++;
    if ({result, we, zero, busy} !== {8'h5A, 3'b000}) begin
      fails++;
      $display("FAIL reserved: result=%h we=%b zero=%b busy=%b, want 5a 0 0 0",
               result, we, zero, busy);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'b000;
    a = 8'h00; b = 8'h00; imm = 8'h00;
    test_reset();
    test_back_to_back();
`ifdef PICO_SIGNED_MUL_EN
    test_mul_run("smuli", 3'b100, 8'hC0, 8'h00, 8'h40, 8'hE0);
    test_mul_run("smul_sat", 3'b101, 8'h80, 8'h80, 8'h00, 8'h7F);
`else
    test_mul_run("muli", 3'b100, 8'hC8, 8'h00, 8'h80, 8'h64);
    test_mul_run("mul_ff", 3'b101, 8'hFF, 8'hFF, 8'h00, 8'hFE);
`endif
    test_start_during_busy();
    test_reset_mid_mul();
    test_reserved();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
